// File: rtl/measure_sequencer_if.sv
// Handshake bundle between the capture sequencer and its controller / sample buffer.
// The slave side is the sequencer; the master side is the MCU glue or a testbench.
interface measure_sequencer_if #(
   parameter int DEPTH = 1024
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic          start;
   logic          abort;
   logic          gain_stable;
   logic          freq_stable;
   logic          sample_tick;
   logic          trig;
   logic          rd_ack;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          wr_bank;
   logic          rd_bank;
   logic          busy;
   logic          ready;
   logic [1:0]    err;
   logic [2:0]    state;

   modport slave (
      input  start, abort, gain_stable, freq_stable, sample_tick, trig, rd_ack,
      output wr_en, wr_addr, wr_bank, rd_bank, busy, ready, err, state
   );

   modport master (
      output start, abort, gain_stable, freq_stable, sample_tick, trig, rd_ack,
      input  wr_en, wr_addr, wr_bank, rd_bank, busy, ready, err, state
   );
endinterface

// File: rtl/measure_sequencer.sv
// Capture sequencer: waits for stable gain/clock, settles, arms on a trigger edge,
// then writes DEPTH samples into a ping-pong buffer bank and hands it to the MCU.
module measure_sequencer #(
   parameter int DEPTH       = 1024,
   parameter int SETTLE_CYC  = 4096,
   parameter int TIMEOUT_CYC = 2**20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   measure_sequencer_if.slave      bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_WAIT_STABLE = 3'd1,
      S_SETTLE      = 3'd2,
      S_ARM         = 3'd3,
      S_CAPTURE     = 3'd4,
      S_DONE        = 3'd5
   } state_t;

   state_t        r_state;
   logic          r_wr_en;
   logic [AW-1:0] r_wr_addr;
   logic          r_wr_bank;
   logic          r_busy;
   logic          r_ready;
   logic [1:0]    r_err;
   logic [SW-1:0] r_settle_cnt;
   logic [TW-1:0] r_to_cnt;
   logic          r_trig_d;

   logic w_stable;
   logic w_trig_rise;
   logic w_to_hit;
   logic w_last_write;
   logic w_ack;

   assign w_stable     = bus.gain_stable & bus.freq_stable;
   assign w_trig_rise  = bus.trig & ~r_trig_d;
   assign w_to_hit     = (r_to_cnt == TW'(TIMEOUT_CYC - 1));
   assign w_last_write = r_wr_en && (r_wr_addr == AW'(DEPTH - 1));
   assign w_ack        = bus.rd_ack & r_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_bank    <= 1'b0;
         r_busy       <= 1'b0;
         r_ready      <= 1'b0;
         r_err        <= 2'b00;
         r_settle_cnt <= '0;
         r_to_cnt     <= '0;
         r_trig_d     <= 1'b0;
      end else begin
         r_trig_d <= bus.trig;
         r_wr_en  <= 1'b0;
         // A DONE in the same clk re-sets ready further down, so the set wins.
         if (w_ack)
            r_ready <= 1'b0;

         if (bus.abort) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_wr_addr <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start) begin
                     r_state  <= S_WAIT_STABLE;
                     r_busy   <= 1'b1;
                     r_err    <= {r_ready, 1'b0};
                     r_to_cnt <= '0;
                  end
               end
               S_WAIT_STABLE: begin
                  if (w_to_hit) begin
                     r_state  <= S_IDLE;
                     r_busy   <= 1'b0;
                     r_err[0] <= 1'b1;
                  end else begin
                     r_to_cnt <= r_to_cnt + TW'(1);
                     if (w_stable) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= SW'(SETTLE_CYC - 1);
                     end
                  end
               end
               S_SETTLE: begin
                  if (!w_stable)
                     r_state <= S_WAIT_STABLE;
                  else if (r_settle_cnt == '0)
                     r_state <= S_ARM;
                  else
                     r_settle_cnt <= r_settle_cnt - SW'(1);
               end
               S_ARM: begin
                  if (w_to_hit) begin
                     r_state  <= S_IDLE;
                     r_busy   <= 1'b0;
                     r_err[0] <= 1'b1;
                  end else begin
                     r_to_cnt <= r_to_cnt + TW'(1);
                     if (w_trig_rise) begin
                        r_state   <= S_CAPTURE;
                        r_wr_addr <= '0;
                     end
                  end
               end
               S_CAPTURE: begin
                  // wr_addr holds the index being written while wr_en is high, then advances.
                  if (!w_stable) begin
                     r_state   <= S_WAIT_STABLE;
                     r_wr_addr <= '0;
                  end else begin
                     if (r_wr_en)
                        r_wr_addr <= r_wr_addr + AW'(1);
                     if (w_last_write)
                        r_state <= S_DONE;
                     else if (bus.sample_tick)
                        r_wr_en <= 1'b1;
                  end
               end
               S_DONE: begin
                  r_wr_bank <= ~r_wr_bank;
                  r_ready   <= 1'b1;
                  r_state   <= S_IDLE;
                  r_busy    <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.wr_en   = r_wr_en;
   assign bus.wr_addr = r_wr_addr;
   assign bus.wr_bank = r_wr_bank;
   assign bus.rd_bank = ~r_wr_bank;
   assign bus.busy    = r_busy;
   assign bus.ready   = r_ready;
   assign bus.err     = r_err;
   assign bus.state   = r_state;
endmodule

// File: doc/measure_sequencer.md
MEASURE_SEQUENCER -- requirements
Module: measure_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning samples per capture (power of two).
REQ-002 SHALL have parameter SETTLE_CYC, default 4096, meaning clk cycles to wait after both stable flags before arming.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2**20, meaning clk cycles allowed in WAIT_STABLE or ARM before abort.
REQ-004 SHALL have port clk, input, 1 bit: the one clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: one-clk pulse that requests a capture.
REQ-007 SHALL have port abort, input, 1 bit: one-clk pulse that cancels the current operation.
REQ-008 SHALL have port gain_stable, input, 1 bit: gain loop settled.
REQ-009 SHALL have port freq_stable, input, 1 bit: ADC clock divider settled.
REQ-010 SHALL have port sample_tick, input, 1 bit: one-clk pulse per ADC sample.
REQ-011 SHALL have port trig, input, 1 bit: synchronized comparator level, used for rising-edge trigger.
REQ-012 SHALL have port rd_ack, input, 1 bit: one-clk pulse, MCU finished reading the ready bank.
REQ-013 SHALL have port wr_en, output, 1 bit: write strobe to the sample buffer.
REQ-014 SHALL have port wr_addr, output, log2(DEPTH) bits: buffer write address.
REQ-015 SHALL have port wr_bank, output, 1 bit: bank being written; rd_bank = ~wr_bank, output, 1 bit.
REQ-016 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-017 SHALL have port ready, output, 1 bit: rd_bank holds a complete, unread capture.
REQ-018 SHALL have port err, output, 2 bits: sticky error; bit0 timeout, bit1 overrun.
REQ-019 SHALL have port state, output, 3 bits: encoding IDLE=0, WAIT_STABLE=1, SETTLE=2, ARM=3, CAPTURE=4, DONE=5.

Function
REQ-020 SHALL, in IDLE, on start: go to WAIT_STABLE, clear err and timeout counter.
REQ-021 SHALL, in WAIT_STABLE, when gain_stable & freq_stable: go to SETTLE and load the settle counter with SETTLE_CYC-1.
REQ-022 SHALL, in SETTLE, decrement each clk; at 0 go to ARM; if either stable flag drops, return to WAIT_STABLE.
REQ-023 SHALL, in ARM, detect a trig rising edge (trig=1, previous clk trig=0), then go to CAPTURE with wr_addr=0.
REQ-024 SHALL, in ARM, treat trig already high on entry as not an edge.
REQ-025 SHALL, in CAPTURE, assert wr_en for exactly the clk of each sample_tick, with wr_addr = sample index; wr_addr increments after each write.
REQ-026 SHALL, when the write at DEPTH-1 completes, go to DONE next clk; wr_addr wraps to 0.
REQ-027 SHALL, in DONE (one clk): toggle wr_bank, set ready, return to IDLE.
REQ-028 SHALL restart from WAIT_STABLE, discarding partial data and keeping wr_bank unchanged, if either stable flag drops during CAPTURE.
REQ-029 SHALL count the timeout counter only in WAIT_STABLE and ARM, and keep it cumulative across re-entries within one request.
REQ-030 SHALL, when the timeout counter reaches TIMEOUT_CYC: set err[0] and go to IDLE.
REQ-031 SHALL, on abort in any state: go to IDLE next clk with no wr_en; ready and wr_bank are unaffected.
REQ-032 SHALL give abort priority over start and over all transitions in the same clk.
REQ-033 SHALL clear ready on rd_ack.
REQ-034 SHALL, on start while ready=1: still proceed, set err[1], and clear ready at DONE before re-setting it.
REQ-035 SHALL let set win when rd_ack and DONE coincide (ready=1).
REQ-036 SHALL ignore start while busy.
REQ-037 SHALL ignore rd_ack while ready=0.
REQ-038 SHALL drive all outputs from registers, except rd_bank, which is combinational from wr_bank.

Reset
REQ-039 SHALL, with rst_n low, asynchronously force: state=IDLE, wr_en=0, wr_addr=0, wr_bank=0, ready=0, err=0, all counters 0, trig history 0.
REQ-040 SHALL apply reset mid-CAPTURE with no further wr_en; the first clk after release is IDLE.

Verification
REQ-041 SHALL cover the nominal case: stable flags high, start, trig edge, 1024 ticks every 4 clk -> 1024 wr_en pulses, addr 0..1023, wr_bank 0->1, ready=1, state back to 0.
REQ-042 SHALL cover a stable-flag drop: gain_stable drops at sample 500 -> state=1, no DONE, wr_bank stays 0; re-stabilize -> full capture completes.
REQ-043 SHALL cover timeout: freq_stable held low after start -> err=01 exactly TIMEOUT_CYC clk later, state=0, busy=0.
REQ-044 SHALL cover overrun: second start without rd_ack -> err=10, ready=1 after second DONE, wr_bank back to 0.
REQ-045 SHALL cover abort vs start: abort and start in the same clk during ARM -> IDLE, no wr_en; a later start is accepted.
REQ-046 SHALL cover asynchronous reset: rst_n pulsed low mid-clk during CAPTURE -> all outputs at reset values before the next clk edge.
